uart_tx_sched: RTL and testbench

- Two-requester scheduler in front of the UART transmitter.
- Requester 0 is the ALU result path, 16-bit, sent as 2 bytes; requester 1 is the register-file read path, 8-bit, sent as 1 byte.
- Arbitrates round-robin, latches the winning word and feeds it byte-by-byte into the UART TX parallel interface, pacing each byte on the transmitter's busy signal.

---
 rtl/uart_tx_sched_pkg.sv | 17 +
 rtl/uart_tx_sched_if.sv | 28 ++
 rtl/uart_tx_sched_rr_arb2.sv | 45 ++++
 rtl/uart_tx_sched.sv | 160 ++++++++++++++++
 tb/tb_uart_tx_sched.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_sched_pkg.sv
// Shared encodings for the UART TX scheduler: FSM states, requester IDs and
// the number of bytes each requester sends per frame.
package uart_tx_sched_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT_HI = 2'd1,
      WAIT_LO = 2'd2
   } state_t;

   localparam logic REQ_ALU = 1'b0;
   localparam logic REQ_RF  = 1'b1;

   localparam int ALU_BYTES = 2;
   localparam int RF_BYTES  = 1;

endpackage

// File: rtl/uart_tx_sched_if.sv
// Requester and transmitter signals of the UART TX scheduler; the scheduler
// uses the slave view, requesters plus transmitter use the master view.
interface uart_tx_sched_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  alu_valid;
   logic [15:0]           alu_data;
   logic                  alu_ack;
   logic                  rf_valid;
   logic [7:0]            rf_data;
   logic                  rf_ack;
   logic [DATA_WIDTH-1:0] TX_P_DATA;
   logic                  TX_D_VALID;
   logic                  TX_BUSY;
   logic                  sched_busy;
   logic                  frame_done;
   logic                  wd_err;

   modport master (
      output alu_valid, alu_data, rf_valid, rf_data, TX_BUSY,
      input  alu_ack, rf_ack, TX_P_DATA, TX_D_VALID, sched_busy, frame_done, wd_err
   );

   modport slave (
      input  alu_valid, alu_data, rf_valid, rf_data, TX_BUSY,
      output alu_ack, rf_ack, TX_P_DATA, TX_D_VALID, sched_busy, frame_done, wd_err
   );
endinterface

// File: rtl/uart_tx_sched_rr_arb2.sv
// Two-input round-robin arbiter. The grant is combinational from the
// registered pointer; update moves the pointer past the last winner.
module rr_arb2
   import uart_tx_sched_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       grant_en,
   input  logic       update,
   output logic [1:0] gnt,
   output logic       gnt_id
);

   logic ptr_q;
   logic last_q;

   always_comb begin
      gnt = 2'b00;
      if (grant_en) begin
         case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (ptr_q == REQ_RF) ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
         endcase
      end
   end

   assign gnt_id = gnt[1];

   // The winner is remembered so the pointer can skip it once its frame ends.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q  <= REQ_ALU;
         last_q <= REQ_ALU;
      end else begin
         if (|gnt)
            last_q <= gnt_id;
         if (update)
            ptr_q <= ~last_q;
      end
   end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler feeding ALU words (2 bytes) and RF bytes into the UART
// TX parallel port. Optional busy watchdog: UART_TX_SCHED_WATCHDOG_EN.
module uart_tx_sched
   import uart_tx_sched_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int WD_CYCLES  = 16
) (
   input  logic            CLK,
   input  logic            RST,
   uart_tx_sched_if.slave  bus
);

   state_t                state_q, state_d;
   logic                  alu_ack_q, alu_ack_d;
   logic                  rf_ack_q, rf_ack_d;
   logic                  tx_valid_q, tx_valid_d;
   logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
   logic                  frame_done_q, frame_done_d;
   logic                  sched_busy_q;
   logic                  bytes_left_q, bytes_left_d;
   logic [DATA_WIDTH-1:0] hi_byte_q, hi_byte_d;
   logic                  arb_en, arb_update;
   logic [1:0]            gnt;
   logic                  gnt_id;
`ifdef UART_TX_SCHED_WATCHDOG_EN
   logic [7:0]            wd_cnt_q, wd_cnt_d;
   logic                  wd_err_q, wd_err_d;
`endif

   rr_arb2 u_arb (
      .clk      (CLK),
      .rst_n    (RST),
      .req      ({bus.rf_valid, bus.alu_valid}),
      .grant_en (arb_en),
      .update   (arb_update),
      .gnt      (gnt),
      .gnt_id   (gnt_id)
   );

   always_comb begin
      state_d      = state_q;
      alu_ack_d    = 1'b0;
      rf_ack_d     = 1'b0;
      tx_valid_d   = 1'b0;
      tx_data_d    = tx_data_q;
      frame_done_d = 1'b0;
      bytes_left_d = bytes_left_q;
      hi_byte_d    = hi_byte_q;
      arb_en       = 1'b0;
      arb_update   = 1'b0;
`ifdef UART_TX_SCHED_WATCHDOG_EN
      wd_cnt_d     = wd_cnt_q;
      wd_err_d     = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            arb_en = !bus.TX_BUSY;
            if (|gnt) begin
               tx_valid_d = 1'b1;
               state_d    = WAIT_HI;
`ifdef UART_TX_SCHED_WATCHDOG_EN
               wd_cnt_d   = 8'd0;
`endif
               if (gnt_id == REQ_ALU) begin
                  alu_ack_d    = 1'b1;
                  tx_data_d    = DATA_WIDTH'(bus.alu_data[7:0]);
                  hi_byte_d    = DATA_WIDTH'(bus.alu_data[15:8]);
                  bytes_left_d = 1'(ALU_BYTES - 1);
               end else begin
                  rf_ack_d     = 1'b1;
                  tx_data_d    = DATA_WIDTH'(bus.rf_data);
                  bytes_left_d = 1'(RF_BYTES - 1);
               end
            end
         end
         WAIT_HI: begin
            if (bus.TX_BUSY)
               state_d = WAIT_LO;
`ifdef UART_TX_SCHED_WATCHDOG_EN
            // Transmitter never acknowledged the byte: drop the frame.
            else if (wd_cnt_q == 8'(WD_CYCLES - 1)) begin
               wd_err_d   = 1'b1;
               arb_update = 1'b1;
               state_d    = IDLE;
            end else
               wd_cnt_d = wd_cnt_q + 8'd1;
`endif
         end
         WAIT_LO: begin
            if (!bus.TX_BUSY) begin
               if (bytes_left_q) begin
                  tx_valid_d   = 1'b1;
                  tx_data_d    = hi_byte_q;
                  bytes_left_d = 1'b0;
                  state_d      = WAIT_HI;
`ifdef UART_TX_SCHED_WATCHDOG_EN
                  wd_cnt_d     = 8'd0;
`endif
               end else begin
                  frame_done_d = 1'b1;
                  arb_update   = 1'b1;
                  state_d      = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q      <= IDLE;
         alu_ack_q    <= 1'b0;
         rf_ack_q     <= 1'b0;
         tx_valid_q   <= 1'b0;
         tx_data_q    <= '0;
         frame_done_q <= 1'b0;
         sched_busy_q <= 1'b0;
         bytes_left_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         alu_ack_q    <= alu_ack_d;
         rf_ack_q     <= rf_ack_d;
         tx_valid_q   <= tx_valid_d;
         tx_data_q    <= tx_data_d;
         frame_done_q <= frame_done_d;
         sched_busy_q <= (state_d != IDLE);
         bytes_left_q <= bytes_left_d;
      end
   end

   // Upper ALU byte is only read after bytes_left is loaded, so it needs no reset.
   always_ff @(posedge CLK) begin
      hi_byte_q <= hi_byte_d;
   end

`ifdef UART_TX_SCHED_WATCHDOG_EN
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         wd_cnt_q <= 8'd0;
         wd_err_q <= 1'b0;
      end else begin
         wd_cnt_q <= wd_cnt_d;
         wd_err_q <= wd_err_d;
      end
   end
   assign bus.wd_err = wd_err_q;
`else
   assign bus.wd_err = 1'b0;
`endif

   assign bus.alu_ack    = alu_ack_q;
   assign bus.rf_ack     = rf_ack_q;
   assign bus.TX_P_DATA  = tx_data_q;
   assign bus.TX_D_VALID = tx_valid_q;
   assign bus.sched_busy = sched_busy_q;
   assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched with a transmitter model that raises busy
// one cycle after TX_D_VALID for 11 cycles. Watchdog checks follow UART_TX_SCHED_WATCHDOG_EN.
module tb_uart_tx_sched;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   logic busy_force = 1'b0;
   logic model_en = 1'b1;
   int   model_cnt;
   int   errors = 0;
   int   checks = 0;
   int   fd_count = 0;
   logic [7:0] exp_q[$];
   logic [7:0] mon_exp;

   always #5 CLK = ~CLK;

   uart_tx_sched_if #(.DATA_WIDTH(8)) ifc ();

   uart_tx_sched #(.DATA_WIDTH(8), .WD_CYCLES(16)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (ifc.slave)
   );

   always @(posedge CLK or negedge RST) begin
      if (!RST)
         model_cnt <= 0;
      else if (model_en && ifc.TX_D_VALID === 1'b1)
         model_cnt <= 11;
      else if (model_cnt != 0)
         model_cnt <= model_cnt - 1;
   end

   assign ifc.TX_BUSY = busy_force | (model_cnt != 0);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every byte the scheduler presents must match the next expected byte.
   always @(negedge CLK) begin
      if (RST === 1'b1) begin
         if (ifc.TX_D_VALID === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL tx_byte: got unexpected byte %0h, none expected (t=%0t)", ifc.TX_P_DATA, $time);
            end else begin
               mon_exp = exp_q.pop_front();
               check("tx_byte", 32'(ifc.TX_P_DATA), 32'(mon_exp));
            end
         end
         if (ifc.frame_done === 1'b1)
            fd_count++;
      end
   end

   task automatic reset_dut();
      ifc.alu_valid = 1'b0;
      ifc.rf_valid  = 1'b0;
      busy_force    = 1'b0;
      RST = 1'b0;
      repeat (2) @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
   endtask

   // Returns at the first negedge where busy is low again after having been high.
   task automatic wait_busy_cycle(input string name);
      int n = 0;
      while (ifc.TX_BUSY !== 1'b1 && n < 60) begin @(negedge CLK); n++; end
      while (ifc.TX_BUSY !== 1'b0 && n < 60) begin @(negedge CLK); n++; end
      check({name, "_bound"}, 32'(n < 60), 32'd1);
   endtask

   initial begin
      int fd0;
      int n;
      int seen;
      logic [1:0] ack_log [3];
      ifc.alu_valid = 1'b0;
      ifc.alu_data  = 16'h0000;
      ifc.rf_valid  = 1'b0;
      ifc.rf_data   = 8'h00;
      #2 RST = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      check("rst_alu_ack", 32'(ifc.alu_ack), 0);
      check("rst_rf_ack", 32'(ifc.rf_ack), 0);
      check("rst_tx_valid", 32'(ifc.TX_D_VALID), 0);
      check("rst_tx_data", 32'(ifc.TX_P_DATA), 0);
      check("rst_sched_busy", 32'(ifc.sched_busy), 0);
      check("rst_frame_done", 32'(ifc.frame_done), 0);
      check("rst_wd_err", 32'(ifc.wd_err), 0);
      RST = 1'b1;
      @(negedge CLK);

      // 1: single RF byte
      fd0 = fd_count;
      exp_q.push_back(8'hA5);
      ifc.rf_data = 8'hA5; ifc.rf_valid = 1'b1;
      @(negedge CLK);
      check("t1_rf_ack", 32'(ifc.rf_ack), 1);
      check("t1_tx_valid", 32'(ifc.TX_D_VALID), 1);
      check("t1_busy_start", 32'(ifc.sched_busy), 1);
      ifc.rf_valid = 1'b0;
      wait_busy_cycle("t1_wait");
      check("t1_busy_mid", 32'(ifc.sched_busy), 1);
      @(negedge CLK);
      check("t1_frame_done", 32'(ifc.frame_done), 1);
      check("t1_busy_end", 32'(ifc.sched_busy), 0);
      @(negedge CLK);
      check("t1_fd_count", 32'(fd_count - fd0), 1);

      // 2: ALU word, low byte first
      fd0 = fd_count;
      exp_q.push_back(8'h34);
      exp_q.push_back(8'h12);
      ifc.alu_data = 16'h1234; ifc.alu_valid = 1'b1;
      @(negedge CLK);
      check("t2_alu_ack", 32'(ifc.alu_ack), 1);
      ifc.alu_valid = 1'b0;
      ifc.alu_data  = 16'hFFFF;
      wait_busy_cycle("t2_wait0");
      check("t2_no_early_byte", 32'(ifc.TX_D_VALID), 0);
      @(negedge CLK);
      check("t2_second_valid", 32'(ifc.TX_D_VALID), 1);
      check("t2_no_fd_mid", 32'(ifc.frame_done), 0);
      wait_busy_cycle("t2_wait1");
      @(negedge CLK);
      check("t2_frame_done", 32'(ifc.frame_done), 1);
      repeat (3) @(negedge CLK);
      check("t2_fd_count", 32'(fd_count - fd0), 1);

      // 3: both requesters held high from reset -> ALU, RF, ALU
      reset_dut();
      fd0 = fd_count;
      exp_q.push_back(8'h34); exp_q.push_back(8'h12);
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h34); exp_q.push_back(8'h12);
      ifc.alu_data = 16'h1234; ifc.rf_data = 8'hA5;
      ifc.alu_valid = 1'b1; ifc.rf_valid = 1'b1;
      seen = 0; n = 0;
      while ((fd_count - fd0) < 3 && n < 400) begin
         @(negedge CLK);
         n++;
         if (seen < 3 && (ifc.alu_ack === 1'b1 || ifc.rf_ack === 1'b1)) begin
            ack_log[seen] = {ifc.rf_ack, ifc.alu_ack};
            seen++;
            if (seen == 3) begin
               ifc.alu_valid = 1'b0; ifc.rf_valid = 1'b0;
            end
         end
      end
      check("t3_bound", 32'(n < 400), 1);
      check("t3_ack_count", 32'(seen), 3);
      check("t3_grant0_alu", 32'(ack_log[0]), 32'b01);
      check("t3_grant1_rf", 32'(ack_log[1]), 32'b10);
      check("t3_grant2_alu", 32'(ack_log[2]), 32'b01);
      repeat (3) @(negedge CLK);
      check("t3_fd_count", 32'(fd_count - fd0), 3);

      // 4: reset during WAIT_LO of the ALU low byte; pending RF is served after
      reset_dut();
      exp_q.push_back(8'h34);
      ifc.alu_data = 16'h1234; ifc.alu_valid = 1'b1;
      @(negedge CLK);
      check("t4_alu_ack", 32'(ifc.alu_ack), 1);
      ifc.alu_valid = 1'b0;
      ifc.rf_data = 8'hA5; ifc.rf_valid = 1'b1;
      n = 0;
      while (ifc.TX_BUSY !== 1'b1 && n < 20) begin @(negedge CLK); n++; end
      repeat (3) @(negedge CLK);
      check("t4_mid_frame_data", 32'(ifc.TX_P_DATA), 32'h34);
      #1 RST = 1'b0;
      #1;
      check("t4_async_tx_data", 32'(ifc.TX_P_DATA), 0);
      check("t4_async_busy", 32'(ifc.sched_busy), 0);
      check("t4_async_outs", 32'({ifc.alu_ack, ifc.rf_ack, ifc.TX_D_VALID, ifc.frame_done, ifc.wd_err}), 0);
      exp_q.push_back(8'hA5);
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      check("t4_rf_ack", 32'(ifc.rf_ack), 1);
      ifc.rf_valid = 1'b0;
      wait_busy_cycle("t4_wait");
      @(negedge CLK);
      check("t4_frame_done", 32'(ifc.frame_done), 1);

      // 5: transmitter never raises busy
      reset_dut();
      model_en = 1'b0;
      fd0 = fd_count;
      exp_q.push_back(8'hA5);
      ifc.rf_data = 8'hA5; ifc.rf_valid = 1'b1;
      @(negedge CLK);
      check("t5_rf_ack", 32'(ifc.rf_ack), 1);
      ifc.rf_valid = 1'b0;
`ifdef UART_TX_SCHED_WATCHDOG_EN
      n = 0;
      while (ifc.wd_err !== 1'b1 && n < 40) begin @(negedge CLK); n++; end
      check("t5_wd_latency", 32'(n), 16);
      check("t5_idle_after_wd", 32'(ifc.sched_busy), 0);
      check("t5_no_frame_done", 32'(ifc.frame_done), 0);
      @(negedge CLK);
      check("t5_wd_pulse", 32'(ifc.wd_err), 0);
      model_en = 1'b1;
      exp_q.push_back(8'h3C);
      ifc.rf_data = 8'h3C; ifc.rf_valid = 1'b1;
      @(negedge CLK);
      check("t5_next_ack", 32'(ifc.rf_ack), 1);
      ifc.rf_valid = 1'b0;
      wait_busy_cycle("t5_wait");
      @(negedge CLK);
      check("t5_next_frame_done", 32'(ifc.frame_done), 1);
      @(negedge CLK);
      check("t5_fd_count", 32'(fd_count - fd0), 1);
`else
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge CLK);
         if (ifc.wd_err === 1'b1) seen++;
      end
      check("t5_no_wd_err", 32'(seen), 0);
      check("t5_still_waiting", 32'(ifc.sched_busy), 1);
      check("t5_fd_count", 32'(fd_count - fd0), 0);
      model_en = 1'b1;
`endif

      // 6: busy already high in IDLE blocks the grant
      reset_dut();
      busy_force = 1'b1;
      exp_q.push_back(8'hC3);
      ifc.rf_data = 8'hC3; ifc.rf_valid = 1'b1;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge CLK);
         if (ifc.rf_ack === 1'b1 || ifc.TX_D_VALID === 1'b1) seen++;
      end
      check("t6_held_off", 32'(seen), 0);
      busy_force = 1'b0;
      @(negedge CLK);
      check("t6_rf_ack", 32'(ifc.rf_ack), 1);
      check("t6_tx_valid", 32'(ifc.TX_D_VALID), 1);
      ifc.rf_valid = 1'b0;
      wait_busy_cycle("t6_wait");
      @(negedge CLK);
      check("t6_frame_done", 32'(ifc.frame_done), 1);

      repeat (3) @(negedge CLK);
      check("queue_empty", 32'(exp_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
